// File: rtl/s2_demux_writer_if.sv
// Producer/consumer bundle for s2_demux_writer: write request, slot select,
// slot contents, occupancy flags and releases.
interface s2_demux_writer_if #(
    parameter int N = 5
);
    logic [N-1:0] DIN;
    logic         A1;
    logic         B1;
    logic         A0;
    logic         B0;
    logic         IN_VALID;
    logic         IN_READY;
    logic [N-1:0] Q00;
    logic [N-1:0] Q01;
    logic [N-1:0] Q10;
    logic [N-1:0] Q11;
    logic [3:0]   FULL;
    logic [3:0]   ACK;
    logic [2:0]   COUNT;
    logic         OVF;

    modport master (
        output DIN, A1, B1, A0, B0, IN_VALID, ACK,
        input  IN_READY, Q00, Q01, Q10, Q11, FULL, COUNT, OVF
    );

    modport slave (
        input  DIN, A1, B1, A0, B0, IN_VALID, ACK,
        output IN_READY, Q00, Q01, Q10, Q11, FULL, COUNT, OVF
    );
endinterface

// File: rtl/s2_demux_writer.sv
// Four-slot demultiplexing writer with per-slot occupancy, release and overflow.
// Define S2_DEMUX_OVERWRITE_EN to let writes to a full slot overwrite it instead of stalling.
module s2_demux_writer #(
    parameter int N = 5
) (
    input  logic              CLK,
    input  logic              CLR,
    s2_demux_writer_if.slave  bus
);
    logic [1:0] sel;
    logic       ready;
    logic       accept;
    logic       ovf_set;
    logic [3:0] full_reg;
    logic [3:0] full_next;
    logic [2:0] count_reg;
    logic [2:0] count_next;
    logic       ovf_reg;

    assign sel = {bus.A1 | bus.B1, bus.A0 & bus.B0};

`ifdef S2_DEMUX_OVERWRITE_EN
    assign ready   = 1'b1;
    // A same-edge release of the target slot makes the write a normal one.
    assign ovf_set = bus.IN_VALID & full_reg[sel] & ~bus.ACK[sel];
`else
    // Ready looks only at registered occupancy, so a same-edge ACK cannot open the slot.
    assign ready   = ~full_reg[sel];
    assign ovf_set = bus.IN_VALID & ~ready;
`endif

    assign accept = bus.IN_VALID & ready;

    always_comb begin
        full_next = full_reg & ~bus.ACK;
        if (accept) begin
            full_next[sel] = 1'b1;
        end
        count_next = '0;
        for (int i = 0; i < 4; i++) begin
            count_next = count_next + {2'b00, full_next[i]};
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            full_reg  <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            full_reg  <= full_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_reg | ovf_set;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            logic [N-1:0] q_reg;
            always_ff @(posedge CLK or posedge CLR) begin
                if (CLR) begin
                    q_reg <= '0;
                end else if (accept && (sel == 2'(gi))) begin
                    q_reg <= bus.DIN;
                end
            end
        end
    endgenerate

    assign bus.IN_READY = ready;
    assign bus.Q00      = g_slot[0].q_reg;
    assign bus.Q01      = g_slot[1].q_reg;
    assign bus.Q10      = g_slot[2].q_reg;
    assign bus.Q11      = g_slot[3].q_reg;
    assign bus.FULL     = full_reg;
    assign bus.COUNT    = count_reg;
    assign bus.OVF      = ovf_reg;
endmodule

// File: doc/s2_demux_writer.md
S2_DEMUX_WRITER -- requirements
Module: s2_demux_writer

Interface
REQ-001 The block SHALL have parameter N, default 5, giving the data word width in bits.
REQ-002 The block SHALL have port CLK, input, 1, the clock; all state updates on its rising edge.
REQ-003 The block SHALL have port CLR, input, 1, reset that is asynchronous and active-high.
REQ-004 The block SHALL have port DIN, input, N, the write data word.
REQ-005 The block SHALL have ports A1, B1, A0, B0, input, 1 each, the slot-select terms.
REQ-006 The block SHALL have port IN_VALID, input, 1, the producer write request.
REQ-007 The block SHALL have port IN_READY, output, 1, the write accept indication.
REQ-008 The block SHALL have ports Q00, Q01, Q10, Q11, output, N each, the registered slot contents.
REQ-009 The block SHALL have port FULL, output, 4, the per-slot occupied flags; bit j corresponds to slot index j.
REQ-010 The block SHALL have port ACK, input, 4, the per-slot consumer release; bit j releases slot j.
REQ-011 The block SHALL have port COUNT, output, 3, the registered number of occupied slots (0..4).
REQ-012 The block SHALL have port OVF, output, 1, a sticky write-overflow flag.

Function
REQ-013 Select SHALL be S1 = A1 OR B1 and S0 = A0 AND B0, with slot index k = {S1,S0}: 00->Q00, 01->Q01, 10->Q10, 11->Q11; k is combinational from the current inputs.
REQ-014 IN_READY SHALL equal NOT FULL[k], combinational from the registered FULL and the current select; it SHALL NOT depend on the same-cycle ACK.
REQ-015 The block SHALL accept a write at a rising edge when IN_VALID=1 and IN_READY=1; on acceptance Q_k <= DIN and FULL[k] <= 1.
REQ-016 Latency SHALL be one edge: the new Q_k, FULL[k] and COUNT are visible after the accepting edge.
REQ-017 Q outputs SHALL change only on an accepted write to their own slot or on CLR.
REQ-018 If ACK[j]=1 and FULL[j]=1 at an edge, FULL[j] SHALL be set to 0 and Q_j SHALL retain its value.
REQ-019 If ACK[j]=1 and FULL[j]=0, the ACK SHALL be ignored.
REQ-020 Multiple ACK bits SHALL be honoured in the same edge.
REQ-021 If a write and an ACK to different slots occur in the same edge, both SHALL take effect.
REQ-022 If IN_VALID=1 and ACK[k]=1 occur while slot k is full, ACK SHALL clear FULL[k] and the write SHALL NOT be accepted (IN_READY=0 that cycle); the producer retries on the next cycle.
REQ-023 COUNT SHALL equal the population count of the next-state FULL, registered.
REQ-024 COUNT SHALL never exceed 4 and SHALL never wrap.
REQ-025 When IN_VALID=1 and IN_READY=0 at an edge, OVF SHALL be set to 1; it SHALL stay 1 until CLR.
REQ-026 DIN and the select inputs SHALL be don't-care when IN_VALID=0.

Reset
REQ-027 While CLR=1, the block SHALL hold Q00..Q11=0, FULL=0000, COUNT=0 and OVF=0 immediately, without waiting for a CLK edge.
REQ-028 During reset IN_READY SHALL be 1.
REQ-029 While CLR=1, writes and ACKs SHALL be ignored.
REQ-030 A CLR asserted mid-operation SHALL discard all slot contents and flags; the first write can be accepted at the first CLK edge after CLR falls.

Configuration
REQ-031 The macro S2_DEMUX_OVERWRITE_EN SHALL select the write policy; without it, the backpressure behaviour of REQ-014, REQ-022 and REQ-025 applies.
REQ-032 With S2_DEMUX_OVERWRITE_EN defined, IN_READY SHALL be tied to 1.
REQ-033 With S2_DEMUX_OVERWRITE_EN defined, a write to a full slot SHALL overwrite Q_k, keep FULL[k]=1, and set OVF.
REQ-034 With S2_DEMUX_OVERWRITE_EN defined, a write plus ACK[k] to the same full slot in one edge SHALL write Q_k, leave FULL[k]=1, and SHALL NOT set OVF.

Verification
REQ-035 The bench SHALL cover basic routing: N=5; A1=0,B1=0,A0=1,B0=1, DIN=5'h0A, IN_VALID=1 for 1 cycle -> Q01=0A, FULL=0010, COUNT=1, other Q=0.
REQ-036 The bench SHALL cover the S1 OR term: A1=0,B1=1,A0=1,B0=0, DIN=5'h15 -> Q10=15, FULL[2]=1; then the same with A1=1,B1=1,A0=1,B0=1, DIN=5'h1F -> Q11=1F, COUNT=2.
REQ-037 The bench SHALL cover backpressure: fill slot 00, then IN_VALID=1 to slot 00 with DIN=5'h03 -> IN_READY=0, Q00 unchanged, OVF=1 and OVF still 1 after 10 idle cycles.
REQ-038 The bench SHALL cover simultaneous ACK and write to the same full slot: slot 00 full, ACK=0001 plus write to slot 00 -> FULL[0]=0, write not accepted; on the next cycle the write is accepted and FULL[0]=1.
REQ-039 The bench SHALL cover ACK plus write to a different slot and a stray ACK: FULL=0001, ACK=0101, write to slot 10 -> FULL=0100, COUNT=1.
REQ-040 The bench SHALL cover asynchronous reset: with all four slots full and OVF=1, pulse CLR between edges -> all Q=0, FULL=0000, COUNT=0, OVF=0 before the next edge; with S2_DEMUX_OVERWRITE_EN defined, repeat REQ-037 -> Q00=03, IN_READY=1, OVF=1.
